// File: rtl/seq_div32x16.sv
// seq_div32x16 -- radix-2 restoring divider, 32-bit dividend by 16-bit divisor.
// Each operand is signed or unsigned per its own flag. Latency is a fixed 34 edges.
// The operation is accepted at edge k, runs 32 CALC iterations on edges k+1..k+32,
// and the FIX edge k+33 registers the result and pulses DONE for one cycle.
//
// Ports:
//   clk    rising-edge clock
//   IRST   synchronous active-high reset
//   START  request, sampled only while idle
//   ASGND  dividend is signed (1) / unsigned (0)
//   BSGND  divisor is signed (1) / unsigned (0)
//   A      dividend, 32 bits
//   B      divisor, 16 bits
//   BUSY   division in progress
//   DONE   one-cycle completion pulse
//   Q      quotient, 32 bits, truncated toward zero
//   R      remainder, 16 bits, takes the sign of the dividend
//   DIVZ   last result was a divide by zero
//   OVF    last result overflowed the signed quotient range
module seq_div32x16 (
  input  logic        clk,
  input  logic        IRST,
  input  logic        START,
  input  logic        ASGND,
  input  logic        BSGND,
  input  logic [31:0] A,
  input  logic [15:0] B,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] Q,
  output logic [15:0] R,
  output logic        DIVZ,
  output logic        OVF
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Two's-complement magnitude. The unsigned result width is enough for the
  // most negative value: |-2^31| = 2^31 and |-2^15| = 2^15 are exact.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    logic signed [31:0] sv;
    sv = v;
    return (sgn && sv[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [15:0] mag16(input logic [15:0] v, input logic sgn);
    logic signed [15:0] sv;
    sv = v;
    return (sgn && sv[15]) ? (~v + 16'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [15:0] neg16(input logic [15:0] v, input logic en);
    return en ? (~v + 16'd1) : v;
  endfunction

  // Signed overflow of the final quotient: a negative result cannot exceed
  // 2^31 in magnitude; a positive result from two signed operands cannot
  // exceed 2^31-1. Unsigned-by-unsigned can never overflow.
  function automatic logic ovf_chk(input logic [31:0] mag, input logic neg,
                                   input logic both_sgn);
    return (neg && (mag > 32'h8000_0000)) || (!neg && both_sgn && mag[31]);
  endfunction

  logic [1:0]  state;
  logic [4:0]  cnt;

  // Datapath state, captured at accept and free of reset.
  logic [31:0] quo;      // dividend bits shift out of the top, quotient bits in at the bottom
  logic [15:0] rem;      // partial remainder, always < |B|
  logic [15:0] bmag;
  logic [15:0] a_lo;     // raw A[15:0], returned as R on divide by zero
  logic        q_neg;
  logic        r_neg;
  logic        both_sgn;
  logic        divz_c;

  // One restoring iteration.
  logic [16:0] shl;
  logic [15:0] diff;
  logic        borrow;
  logic [15:0] rem_nxt;
  logic        qbit;

  always_comb begin
    shl     = {rem, quo[31]};
    borrow  = (shl < {1'b0, bmag});
    // When no borrow occurs the true difference is below |B|, so 16 bits hold it.
    diff    = shl[15:0] - bmag;
    rem_nxt = borrow ? shl[15:0] : diff;
    qbit    = ~borrow;
  end

  // Control: state, counter and architectural outputs.
  always_ff @(posedge clk) begin
    if (IRST) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      Q     <= 32'd0;
      R     <= 16'd0;
      DIVZ  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_CALC;
            cnt   <= 5'd31;
            BUSY  <= 1'b1;
          end
        end
        S_CALC: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= S_FIX;
        end
        S_FIX: begin
          if (divz_c) begin
            Q    <= 32'hFFFF_FFFF;
            R    <= a_lo;
            DIVZ <= 1'b1;
            OVF  <= 1'b0;
          end else begin
            Q    <= neg32(quo, q_neg);
            R    <= neg16(rem, r_neg);
            DIVZ <= 1'b0;
            OVF  <= ovf_chk(quo, q_neg, both_sgn);
          end
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operands are captured only on the accept edge, so later input
  // changes have no effect on the running division.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && START) begin
      quo      <= mag32(A, ASGND);
      bmag     <= mag16(B, BSGND);
      rem      <= 16'd0;
      a_lo     <= A[15:0];
      q_neg    <= (ASGND & A[31]) ^ (BSGND & B[15]);
      r_neg    <= ASGND & A[31];
      both_sgn <= ASGND & BSGND;
      divz_c   <= (B == 16'd0);
    end else if (state == S_CALC) begin
      rem <= rem_nxt;
      quo <= {quo[30:0], qbit};
    end
  end

endmodule

// File: tb/tb_seq_div32x16.sv
// tb_seq_div32x16 -- directed table vectors, hand-written multi-cycle sequences
// (reset abort, reset priority, back-to-back) and a reference-model sweep.
module tb_seq_div32x16;

  logic        clk;
  logic        IRST;
  logic        START;
  logic        ASGND;
  logic        BSGND;
  logic [31:0] A;
  logic [15:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] Q;
  logic [15:0] R;
  logic        DIVZ;
  logic        OVF;

  int nvec  = 0;
  int nfail = 0;

  seq_div32x16 dut (
    .clk   (clk),
    .IRST  (IRST),
    .START (START),
    .ASGND (ASGND),
    .BSGND (BSGND),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Q     (Q),
    .R     (R),
    .DIVZ  (DIVZ),
    .OVF   (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic        as;
    logic        bs;
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result packed as {Q, R, DIVZ, OVF}.
  function automatic logic [49:0] result();
    return {Q, R, DIVZ, OVF};
  endfunction

  function automatic logic [49:0] model(input logic [31:0] a, input logic [15:0] b,
                                        input logic as, input logic bs);
    longint av, bv, qq, rr;
    logic   ov;
    av = as ? longint'($signed(a)) : longint'({32'd0, a});
    bv = bs ? longint'($signed(b)) : longint'({48'd0, b});
    if (bv == 0) return {32'hFFFF_FFFF, a[15:0], 1'b1, 1'b0};
    qq = av / bv;
    rr = av % bv;
    ov = (qq < -64'sd2147483648) || (as && bs && (qq > 64'sd2147483647));
    return {qq[31:0], rr[15:0], 1'b0, ov};
  endfunction

  // Present an operation before an edge; returns just after the edge.
  task automatic launch(input logic [31:0] a, input logic [15:0] b,
                        input logic as, input logic bs);
    @(negedge clk);
    A = a; B = b; ASGND = as; BSGND = bs; START = 1'b1;
    @(posedge clk); #1;
  endtask

  // Count edges until DONE is seen; a bound expiry counts as a miscompare.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (DONE) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      nvec++;
      nfail++;
      $display("FAIL timeout: no DONE within 60 cycles");
    end
  endtask

  // Full single operation: latency, result, pulse width and hold.
  task automatic run_one(input string nm, input logic [31:0] a, input logic [15:0] b,
                         input logic as, input logic bs, input logic [49:0] exp);
    int n;
    logic [49:0] res;
    launch(a, b, as, bs);
    START = 1'b0;
    // Scramble inputs mid-operation; they must not matter.
    A = ~a; B = ~b; ASGND = ~as; BSGND = ~bs;
    wait_done(n);
    chk({nm, " latency"}, 64'(n), 64'd33);
    res = result();
    chk({nm, " result"}, 64'(res), 64'(exp));
    @(posedge clk); #1;
    chk({nm, " pulse/hold"}, 64'({DONE, BUSY, result()}), 64'({1'b0, 1'b0, exp}));
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] ra;
    logic [15:0] rb;
    logic        ras, rbs;

    tbl[0]  = '{32'd100,       16'd7,      1'b0, 1'b0, 32'd14,        16'd2,      1'b0, 1'b0};
    tbl[1]  = '{32'hFFFFFF9C,  16'd7,      1'b1, 1'b1, 32'hFFFFFFF2,  16'hFFFE,   1'b0, 1'b0};
    tbl[2]  = '{32'd100,       16'hFFF9,   1'b1, 1'b1, 32'hFFFFFFF2,  16'd2,      1'b0, 1'b0};
    tbl[3]  = '{32'h12345678,  16'd0,      1'b0, 1'b0, 32'hFFFFFFFF,  16'h5678,   1'b1, 1'b0};
    tbl[4]  = '{32'h80000000,  16'hFFFF,   1'b1, 1'b1, 32'h80000000,  16'd0,      1'b0, 1'b1};
    tbl[5]  = '{32'hFFFFFFFF,  16'd1,      1'b0, 1'b0, 32'hFFFFFFFF,  16'd0,      1'b0, 1'b0};
    tbl[6]  = '{32'hFFFFFF9C,  16'hFFF9,   1'b1, 1'b1, 32'd14,        16'hFFFE,   1'b0, 1'b0};
    tbl[7]  = '{32'hFFFFFFFF,  16'hFFFF,   1'b0, 1'b0, 32'h00010001,  16'd0,      1'b0, 1'b0};
    tbl[8]  = '{32'h80000000,  16'h8000,   1'b1, 1'b1, 32'h00010000,  16'd0,      1'b0, 1'b0};
    tbl[9]  = '{32'hFFFFFF9C,  16'd7,      1'b1, 1'b0, 32'hFFFFFFF2,  16'hFFFE,   1'b0, 1'b0};
    tbl[10] = '{32'd100,       16'hFFF9,   1'b0, 1'b0, 32'd0,         16'd100,    1'b0, 1'b0};
    tbl[11] = '{32'hFFFF8000,  16'd0,      1'b1, 1'b1, 32'hFFFFFFFF,  16'h8000,   1'b1, 1'b0};
    tbl[12] = '{32'h7FFFFFFF,  16'd1,      1'b1, 1'b1, 32'h7FFFFFFF,  16'd0,      1'b0, 1'b0};
    tbl[13] = '{32'hFFFFFFF9,  16'd100,    1'b1, 1'b1, 32'd0,         16'hFFF9,   1'b0, 1'b0};

    IRST = 1'b1; START = 1'b0; ASGND = 1'b0; BSGND = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", 64'({BUSY, DONE, result()}), 64'd0);
    @(negedge clk);
    IRST = 1'b0;

    foreach (tbl[i])
      run_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].as, tbl[i].bs,
              {tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov});

    // Reset in the middle of CALC aborts with no DONE and clears outputs.
    launch(32'd1000, 16'd3, 1'b0, 1'b0);
    START = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    IRST = 1'b1;
    @(posedge clk); #1;
    chk("abort outputs", 64'({BUSY, DONE, result()}), 64'd0);
    IRST = 1'b0;
    seen = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (DONE) seen++;
    end
    chk("abort no DONE", 64'(seen), 64'd0);

    // Reset wins over a simultaneous START.
    @(negedge clk);
    IRST = 1'b1; START = 1'b1; A = 32'd50; B = 16'd5;
    @(posedge clk); #1;
    chk("reset priority", 64'({BUSY, DONE}), 64'd0);
    IRST = 1'b0; START = 1'b0;

    // First START after reset completes normally.
    run_one("after reset", 32'd1000, 16'd3, 1'b0, 1'b0, {32'd333, 16'd1, 1'b0, 1'b0});

    // Back-to-back with START held high; operands change during BUSY.
    launch(32'd100, 16'd7, 1'b0, 1'b0);
    chk("b2b busy", 64'(BUSY), 64'd1);
    A = 32'hFFFFFF9C; B = 16'd7; ASGND = 1'b1; BSGND = 1'b1;
    wait_done(n);
    chk("b2b lat1", 64'(n), 64'd33);
    chk("b2b res1", 64'(result()), 64'({32'd14, 16'd2, 1'b0, 1'b0}));
    wait_done(n);
    START = 1'b0;
    chk("b2b spacing", 64'(n), 64'd34);
    chk("b2b res2", 64'(result()), 64'({32'hFFFFFFF2, 16'hFFFE, 1'b0, 1'b0}));
    @(posedge clk); #1;
    chk("b2b idle", 64'({BUSY, DONE}), 64'd0);

    // Reference-model sweep with biased corner operands.
    for (int i = 0; i < 250; i++) begin
      ra  = $urandom;
      rb  = 16'($urandom);
      ras = 1'($urandom);
      rbs = 1'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'd0;
        1: rb = 16'hFFFF;
        2: ra = 32'h80000000;
        3: rb = 16'($urandom_range(1, 9));
        4: rb = 16'h8000;
        default: ;
      endcase
      run_one($sformatf("rand%0d", i), ra, rb, ras, rbs, model(ra, rb, ras, rbs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
